// File: rtl/zh_lkt_pkg.sv
// Shared FSM state encoding and default sizing for the 1-hot reverse lookup.
// Optional multi-hit detection elsewhere is enabled by ZH_RLKT_MULTI_HIT_CHK_EN.
package zh_lkt_pkg;

  localparam int unsigned DEF_RESULT_WIDTH = 3;
  localparam int unsigned DEF_NUM_LOOKUPS  = 8;
  localparam int unsigned DEF_NUM_CHOICES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RESP
  } state_t;

endpackage

// File: rtl/zh_1hot_region_match.sv
// Compares one region's entries against a target: lowest-index one-hot, hit, multi.
// o_multi is only computed with ZH_RLKT_MULTI_HIT_CHK_EN defined, else tied low.
module zh_1hot_region_match
  import zh_lkt_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int unsigned NUM_CHOICES  = DEF_NUM_CHOICES
) (
  input  logic [NUM_CHOICES*RESULT_WIDTH-1:0] i_row,
  input  logic [RESULT_WIDTH-1:0]             i_target,
  output logic [NUM_CHOICES-1:0]              o_onehot,
  output logic                                o_hit,
  output logic                                o_multi
);

  logic [NUM_CHOICES-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int g = 0; g < NUM_CHOICES; g++) begin
      w_match[g] = (i_row[g*RESULT_WIDTH +: RESULT_WIDTH] == i_target);
    end
  end

  always_comb begin
    logic w_found;
    w_found  = 1'b0;
    o_onehot = '0;
    for (int g = 0; g < NUM_CHOICES; g++) begin
      if (w_match[g] && !w_found) begin
        o_onehot[g] = 1'b1;
        w_found     = 1'b1;
      end
    end
    o_hit = w_found;
  end

`ifdef ZH_RLKT_MULTI_HIT_CHK_EN
  always_comb begin
    logic w_seen;
    w_seen  = 1'b0;
    o_multi = 1'b0;
    for (int g = 0; g < NUM_CHOICES; g++) begin
      if (w_match[g]) begin
        if (w_seen) o_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end
`else
  assign o_multi = 1'b0;
`endif

endmodule

// File: rtl/zh_1hot_reverse_lookup.sv
// Reverse 1-hot lookup: scans one region per cycle, returns per-region selectors.
// Multi-hit flags need ZH_RLKT_MULTI_HIT_CHK_EN; otherwise rsp_multi_o stays 0.
module zh_1hot_reverse_lookup
  import zh_lkt_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int unsigned NUM_LOOKUPS  = DEF_NUM_LOOKUPS,
  parameter int unsigned NUM_CHOICES  = DEF_NUM_CHOICES
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          tbl_wr_en_i,
  input  logic [$clog2(NUM_LOOKUPS)-1:0]                tbl_wr_lookup_i,
  input  logic [$clog2(NUM_CHOICES)-1:0]                tbl_wr_choice_i,
  input  logic [RESULT_WIDTH-1:0]                       tbl_wr_data_i,
  output logic [NUM_LOOKUPS*NUM_CHOICES*RESULT_WIDTH-1:0] lookup_table_o,
  input  logic                                          req_valid_i,
  output logic                                          req_ready_o,
  input  logic [RESULT_WIDTH*NUM_LOOKUPS-1:0]           req_value_i,
  output logic                                          rsp_valid_o,
  input  logic                                          rsp_ready_i,
  output logic [NUM_LOOKUPS*NUM_CHOICES-1:0]            rsp_onehot_o,
  output logic [NUM_LOOKUPS-1:0]                        rsp_hit_o,
  output logic [NUM_LOOKUPS-1:0]                        rsp_multi_o
);

  localparam int unsigned LW = $clog2(NUM_LOOKUPS);
  localparam int unsigned CW = $clog2(NUM_CHOICES);
  localparam int unsigned RW = NUM_CHOICES*RESULT_WIDTH;
  localparam logic [LW-1:0] LAST = LW'(NUM_LOOKUPS-1);

  logic [NUM_LOOKUPS*RW-1:0]         r_tbl;
  state_t                            r_state;
  logic [LW-1:0]                     r_idx;
  logic                              r_issue_done;
  logic [RESULT_WIDTH*NUM_LOOKUPS-1:0] r_target;
  logic                              r_pend_vld;
  logic [LW-1:0]                     r_pend_idx;
  logic [NUM_CHOICES-1:0]            r_pend_oh;
  logic                              r_pend_hit;
  logic                              r_pend_multi;
  logic [NUM_LOOKUPS*NUM_CHOICES-1:0] r_oh;
  logic [NUM_LOOKUPS-1:0]            r_hit;
  logic [NUM_LOOKUPS-1:0]            r_multi;
  logic                              r_rsp_valid;

  logic [RW-1:0]           w_row;
  logic [RESULT_WIDTH-1:0] w_target;
  logic [NUM_CHOICES-1:0]  w_oh;
  logic                    w_hit;
  logic                    w_multi;

  // Writes are accepted in every state; a scan sees the table as of cycle start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tbl <= '0;
    end else if (tbl_wr_en_i) begin
      for (int f = 0; f < NUM_LOOKUPS; f++) begin
        for (int g = 0; g < NUM_CHOICES; g++) begin
          if (tbl_wr_lookup_i == LW'(f) && tbl_wr_choice_i == CW'(g)) begin
            r_tbl[(f*NUM_CHOICES+g)*RESULT_WIDTH +: RESULT_WIDTH] <= tbl_wr_data_i;
          end
        end
      end
    end
  end

  always_comb begin
    w_row    = '0;
    w_target = '0;
    for (int f = 0; f < NUM_LOOKUPS; f++) begin
      if (r_idx == LW'(f)) begin
        w_row    = r_tbl[f*RW +: RW];
        w_target = r_target[f*RESULT_WIDTH +: RESULT_WIDTH];
      end
    end
  end

  zh_1hot_region_match #(
    .RESULT_WIDTH (RESULT_WIDTH),
    .NUM_CHOICES  (NUM_CHOICES)
  ) u_match (
    .i_row    (w_row),
    .i_target (w_target),
    .o_onehot (w_oh),
    .o_hit    (w_hit),
    .o_multi  (w_multi)
  );

  // Compare stage feeds a commit stage, so the last region lands one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_issue_done <= 1'b0;
      r_target     <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_oh    <= '0;
      r_pend_hit   <= 1'b0;
      r_pend_multi <= 1'b0;
      r_oh         <= '0;
      r_hit        <= '0;
      r_multi      <= '0;
      r_rsp_valid  <= 1'b0;
    end else begin
      r_pend_vld <= 1'b0;
      if (r_pend_vld) begin
        for (int f = 0; f < NUM_LOOKUPS; f++) begin
          if (r_pend_idx == LW'(f)) begin
            r_oh[f*NUM_CHOICES +: NUM_CHOICES] <= r_pend_oh;
            r_hit[f]   <= r_pend_hit;
            r_multi[f] <= r_pend_multi;
          end
        end
      end
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_target     <= req_value_i;
            r_idx        <= '0;
            r_issue_done <= 1'b0;
            r_state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!r_issue_done) begin
            r_pend_vld   <= 1'b1;
            r_pend_idx   <= r_idx;
            r_pend_oh    <= w_oh;
            r_pend_hit   <= w_hit;
            r_pend_multi <= w_multi;
            if (r_idx == LAST) r_issue_done <= 1'b1;
            else               r_idx <= r_idx + LW'(1);
          end
          if (r_pend_vld && r_pend_idx == LAST) begin
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign lookup_table_o = r_tbl;
  assign req_ready_o    = rst_n & (r_state == ST_IDLE);
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_onehot_o   = r_oh;
  assign rsp_hit_o      = r_hit;
  assign rsp_multi_o    = r_multi;

endmodule

// File: tb/tb_zh_1hot_reverse_lookup.sv
// Scoreboard bench for zh_1hot_reverse_lookup (default sizing 3/8/2).
// Multi-hit expectations follow ZH_RLKT_MULTI_HIT_CHK_EN.
module tb_zh_1hot_reverse_lookup;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tbl_wr_en_i;
  logic [2:0]  tbl_wr_lookup_i;
  logic        tbl_wr_choice_i;
  logic [2:0]  tbl_wr_data_i;
  logic [47:0] lookup_table_o;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [23:0] req_value_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_onehot_o;
  logic [7:0]  rsp_hit_o;
  logic [7:0]  rsp_multi_o;

  always #5 clk = ~clk;

  zh_1hot_reverse_lookup dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tbl_wr_en_i     (tbl_wr_en_i),
    .tbl_wr_lookup_i (tbl_wr_lookup_i),
    .tbl_wr_choice_i (tbl_wr_choice_i),
    .tbl_wr_data_i   (tbl_wr_data_i),
    .lookup_table_o  (lookup_table_o),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_value_i     (req_value_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_onehot_o    (rsp_onehot_o),
    .rsp_hit_o       (rsp_hit_o),
    .rsp_multi_o     (rsp_multi_o)
  );

  typedef struct {
    logic [15:0] oh;
    logic [7:0]  hit;
    logic [7:0]  multi;
    int          hs;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rsp_hs_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mx(input logic [7:0] m);
`ifdef ZH_RLKT_MULTI_HIT_CHK_EN
    return m;
`else
    return 8'h00;
`endif
  endfunction

  // Monitor: checks each response against the scoreboard head.
  logic        prev_v = 1'b0;
  exp_t        cur;
  logic [15:0] s_oh;
  logic [7:0]  s_hit;
  logic [7:0]  s_multi;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid_o) begin
        chk("req_ready_in_resp", req_ready_o, 1'b0);
        if (!prev_v) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got onehot %0h expected none",
                     rsp_onehot_o);
          end else begin
            cur = sb[0];
            chk("latency", cyc - cur.hs, N + 1);
            chk("onehot", rsp_onehot_o, cur.oh);
            chk("hit", rsp_hit_o, cur.hit);
            chk("multi", rsp_multi_o, cur.multi);
          end
          s_oh    = rsp_onehot_o;
          s_hit   = rsp_hit_o;
          s_multi = rsp_multi_o;
        end else begin
          chk("hold_onehot", rsp_onehot_o, s_oh);
          chk("hold_hit", rsp_hit_o, s_hit);
          chk("hold_multi", rsp_multi_o, s_multi);
        end
        if (rsp_ready_i) begin
          if (sb.size() > 0) void'(sb.pop_front());
          rsp_hs_cyc = cyc + 1;
        end
      end
      prev_v = rsp_valid_o;
    end
  end

  task automatic wr(input logic [2:0] lk, input logic ch, input logic [2:0] d);
    @(posedge clk); #1;
    tbl_wr_en_i     = 1'b1;
    tbl_wr_lookup_i = lk;
    tbl_wr_choice_i = ch;
    tbl_wr_data_i   = d;
    @(posedge clk); #1;
    tbl_wr_en_i = 1'b0;
  endtask

  task automatic accept(input logic [15:0] oh, input logic [7:0] hit,
                        input logic [7:0] multi, input bit push,
                        output int hs);
    bit ok;
    ok = 1'b0;
    hs = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL req_accept: got no ready expected ready within 100");
      req_valid_i = 1'b0;
    end else begin
      @(posedge clk); #1;
      hs = cyc;
      req_valid_i = 1'b0;
      if (push) sb.push_back('{oh, hit, mx(multi), hs});
    end
  endtask

  task automatic issue(input logic [23:0] v, input logic [15:0] oh,
                       input logic [7:0] hit, input logic [7:0] multi,
                       input bit push, output int hs);
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    req_value_i = v;
    accept(oh, hit, multi, push, hs);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready_o, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
    chk({tag, "_onehot"}, rsp_onehot_o, 16'h0);
    chk({tag, "_hit"}, rsp_hit_o, 8'h0);
    chk({tag, "_multi"}, rsp_multi_o, 8'h0);
    chk({tag, "_table"}, lookup_table_o, 48'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, hs2;
    bit ok;
    rst_n           = 1'b0;
    tbl_wr_en_i     = 1'b0;
    tbl_wr_lookup_i = '0;
    tbl_wr_choice_i = 1'b0;
    tbl_wr_data_i   = '0;
    req_valid_i     = 1'b0;
    req_value_i     = '0;
    rsp_ready_i     = 1'b1;

    #12;
    chk_reset_outputs("reset");
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", req_ready_o, 1'b1);

    wr(3'd0, 1'b0, 3'd5);
    wr(3'd0, 1'b1, 3'd2);
    wr(3'd3, 1'b0, 3'd6);
    wr(3'd3, 1'b1, 3'd6);
    wr(3'd4, 1'b0, 3'd1);
    wr(3'd4, 1'b1, 3'd3);
    @(negedge clk);
    chk("table_after_writes", lookup_table_o,
        {6'b0, 6'b0, 6'b0, 6'b011001, 6'b110110, 6'b0, 6'b0, 6'b010101});

    // r0=2 -> choice1, r3=6 -> choice0 + multi, r4=7 -> miss, rest 0 hit zeros
    issue({3'd0, 3'd0, 3'd0, 3'd7, 3'd6, 3'd0, 3'd0, 3'd2},
          16'h5456, 8'hef, 8'hee, 1'b1, hs);
    wait_idle();

    // Response back-pressure with a second request waiting
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    issue(24'h0, 16'h5414, 8'he6, 8'he6, 1'b1, hs);
    req_valid_i = 1'b1;
    req_value_i = {3'd7, 3'd7, 3'd7, 3'd3, 3'd6, 3'd7, 3'd7, 3'd5};
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL bp_rsp_valid: got 0 expected 1");
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    accept(16'h0241, 8'h19, 8'h08, 1'b1, hs2);
    chk("held_req_accept_cycle", hs2, rsp_hs_cyc + 1);
    wait_idle();

    // Write region 7 choice 1 during the second scan cycle
    issue({3'd4, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7},
          16'h8000, 8'h80, 8'h00, 1'b1, hs);
    @(posedge clk); #1;
    tbl_wr_en_i     = 1'b1;
    tbl_wr_lookup_i = 3'd7;
    tbl_wr_choice_i = 1'b1;
    tbl_wr_data_i   = 3'd4;
    @(posedge clk); #1;
    tbl_wr_en_i = 1'b0;
    wait_idle();
    chk("table_after_scan_write", lookup_table_o,
        {6'b100000, 6'b0, 6'b0, 6'b011001, 6'b110110, 6'b0, 6'b0, 6'b010101});

    // Reset mid-scan: the aborted request must never respond
    issue(24'h0, 16'h0, 8'h0, 8'h0, 1'b0, hs);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midscan_reset");
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_midscan_reset", req_ready_o, 1'b1);
    repeat (12) @(negedge clk);
    issue(24'h0, 16'h5555, 8'hff, 8'hff, 1'b1, hs);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zh_1hot_reverse_lookup.md
ZH_1HOT_REVERSE_LOOKUP -- requirements
Module: zh_1hot_reverse_lookup

Interface
REQ-001 SHALL have parameter RESULT_WIDTH, default 3, bit width of one table entry.
REQ-002 SHALL have parameter NUM_LOOKUPS, default 8, number of independent lookup regions.
REQ-003 SHALL have parameter NUM_CHOICES, default 2, entries per region.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tbl_wr_en_i  input  1  table entry write strobe.
REQ-007 SHALL have port tbl_wr_lookup_i  input  $clog2(NUM_LOOKUPS)  region index of the write.
REQ-008 SHALL have port tbl_wr_choice_i  input  $clog2(NUM_CHOICES)  entry index of the write.
REQ-009 SHALL have port tbl_wr_data_i  input  RESULT_WIDTH  value to write.
REQ-010 SHALL have port lookup_table_o  output  NUM_LOOKUPS*NUM_CHOICES*RESULT_WIDTH  stored table; entry (f,g) at bits f*NUM_CHOICES*RESULT_WIDTH+g*RESULT_WIDTH +: RESULT_WIDTH.
REQ-011 SHALL have port req_valid_i  input  1  reverse-lookup request valid.
REQ-012 SHALL have port req_ready_o  output  1  request accepted when valid and ready both high.
REQ-013 SHALL have port req_value_i  input  RESULT_WIDTH*NUM_LOOKUPS  target value per region, region f at f*RESULT_WIDTH +: RESULT_WIDTH.
REQ-014 SHALL have port rsp_valid_o  output  1  response valid.
REQ-015 SHALL have port rsp_ready_i  input  1  response consumed when valid and ready both high.
REQ-016 SHALL have port rsp_onehot_o  output  NUM_LOOKUPS*NUM_CHOICES  per-region one-hot selector, region f at f*NUM_CHOICES +: NUM_CHOICES; all-zero on miss.
REQ-017 SHALL have port rsp_hit_o  output  NUM_LOOKUPS  per-region hit flag.
REQ-018 SHALL have port rsp_multi_o  output  NUM_LOOKUPS  per-region multiple-match flag.

Function
REQ-019 SHALL write table entry (tbl_wr_lookup_i, tbl_wr_choice_i) with tbl_wr_data_i at the clock edge where tbl_wr_en_i is high, in any FSM state; out-of-range indices SHALL be ignored.
REQ-020 SHALL run FSM IDLE -> SCAN on request handshake, SCAN -> RESP after region NUM_LOOKUPS-1 is scanned, RESP -> IDLE on response handshake.
REQ-021 SHALL drive req_ready_o high only in IDLE, and SHALL register req_value_i at the handshake.
REQ-022 SHALL scan one region per SCAN cycle, index 0 upward, comparing all NUM_CHOICES entries against the registered target using table contents as stored at the start of that cycle.
REQ-023 SHALL, per region, set the one-hot bit of the lowest-index matching choice, set rsp_hit_o when any choice matches, and clear both on no match.
REQ-024 SHALL assert rsp_valid_o exactly NUM_LOOKUPS+1 cycles after the request-handshake edge and hold all rsp_* outputs stable until rsp_ready_i is sampled high.
REQ-025 SHALL accept no new request on the response-handshake cycle; the earliest next acceptance is the cycle after return to IDLE.
REQ-026 SHALL guarantee that feeding rsp_onehot_o and lookup_table_o into the forward 1-hot lookup table yields req_value_i for every hit region.

Reset
REQ-027 SHALL, on rst_n low, asynchronously enter IDLE, clear all table entries to 0, and drive req_ready_o=0 during reset, rsp_valid_o=0, rsp_onehot_o=0, rsp_hit_o=0, rsp_multi_o=0.
REQ-028 SHALL abandon any in-flight scan or pending response on reset without emitting a response; req_ready_o SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 SHALL, with ZH_RLKT_MULTI_HIT_CHK_EN defined, set rsp_multi_o bit f when two or more choices of region f match.
REQ-030 SHALL, without ZH_RLKT_MULTI_HIT_CHK_EN, tie rsp_multi_o to 0 and omit its comparison logic; all other behaviour identical.

Structure
REQ-031 SHALL place the FSM state enum and the default parameter constants in a shared package zh_lkt_pkg.
REQ-032 SHALL instantiate one sub-module zh_1hot_region_match (NUM_CHOICES entries, one target in; lowest-index one-hot, hit, multi out) used by the scan datapath.

Verification
REQ-033 SHALL cover: reset, region 0 choices {5,2}, request region0=2 -> after 9 cycles rsp_onehot_o[1:0]=2'b10, rsp_hit_o[0]=1.
REQ-034 SHALL cover: region 3 choices {6,6}, target 6 -> onehot 2'b01, hit=1, rsp_multi_o[3]=1 with macro, 0 without.
REQ-035 SHALL cover: region 4 choices {1,3}, target 7 -> onehot 2'b00, hit=0.
REQ-036 SHALL cover: rsp_ready_i held low 5 cycles -> rsp_* stable, req_ready_o=0 throughout; request held valid is accepted only after return to IDLE.
REQ-037 SHALL cover: write region 7 choice 1 := 4 during SCAN cycle 2, target 4 -> hit at onehot 2'b10, since region 7 is scanned after the write.
REQ-038 SHALL cover: rst_n pulsed low mid-SCAN -> no response, table reads all-zero, next request for target 0 returns onehot 2'b01 in every region.
